// File: rtl/halt_ctrl_pkg.sv
// Shared types and constants for the core halt controller.
package halt_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT_REQ,
    HALTED,
    RESTART
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_INSTR = 2'b01;
  localparam logic [1:0] CAUSE_DEBUG = 2'b10;
  localparam logic [1:0] CAUSE_BOTH  = 2'b11;

  // Width of the shared restart/timeout counter; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/halt_controller_cycle_counter.sv
// Loadable up/down counter with enable, saturation at both ends and zero/terminal flags.
module cycle_counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] TERMINAL    = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic             zero,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      if (up && !terminal) begin
        count <= count + WIDTH'(1);
      end else if (!up && !zero) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    zero     = (count == '0);
    terminal = (count == TERMINAL);
  end

endmodule

// File: rtl/halt_controller.sv
// Halt-protocol initiator: requests a core stall, waits for Halted, reports to the
// debug host and issues a timed core reset pulse on resume.
module halt_controller
  import halt_ctrl_pkg::*;
#(
  parameter int RESTART_CYCLES = 4,
  parameter int HALT_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       async_rst,
  input  logic       clk_en,
  input  logic       InstructionValid,
  input  logic       HaltInstr,
  input  logic       DebugHaltReq,
  input  logic       DebugResumeReq,
  input  logic       Halted,
  output logic       HaltStallOut,
  output logic       CoreSyncRst,
  output logic       HaltAck,
  output logic [1:0] HaltCause,
  output logic       HaltTimeout,
  output logic       Running
);

  localparam int           W        = cnt_width(RESTART_CYCLES, HALT_TIMEOUT);
  localparam logic [W-1:0] RST_LOAD = W'(RESTART_CYCLES - 1);
  localparam logic [W-1:0] TMO_LAST = W'(HALT_TIMEOUT - 1);

  state_t       state;
  logic         req_i;
  logic         req_d;
  logic         stall_q;
  logic         cnt_load;
  logic [W-1:0] cnt_load_value;
  logic         cnt_en;
  logic         cnt_up;
  logic         cnt_zero;
  logic         cnt_terminal;

  // One counter serves both the restart pulse (down) and the halt timeout (up).
  always_comb begin
    req_i          = InstructionValid && HaltInstr && clk_en;
    req_d          = DebugHaltReq;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    cnt_up         = 1'b0;
    unique case (state)
      RUN: begin
        cnt_load = req_i || req_d;
      end
      HALT_REQ: begin
        cnt_en = clk_en && !Halted;
        cnt_up = 1'b1;
      end
      HALTED: begin
        cnt_load       = DebugResumeReq;
        cnt_load_value = RST_LOAD;
      end
      RESTART: begin
        cnt_en = 1'b1;
      end
      default: ;
    endcase
    HaltStallOut = stall_q || ((state == RUN) && (req_i || req_d));
  end

  cycle_counter #(
    .WIDTH       (W),
    .RESET_VALUE (RST_LOAD),
    .TERMINAL    (TMO_LAST)
  ) u_counter (
    .clk        (clk),
    .rst        (async_rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .up         (cnt_up),
    .zero       (cnt_zero),
    .terminal   (cnt_terminal)
  );

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state       <= RESTART;
      HaltCause   <= CAUSE_NONE;
      HaltTimeout <= 1'b0;
      stall_q     <= 1'b0;
      CoreSyncRst <= 1'b1;
      HaltAck     <= 1'b0;
      Running     <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (req_i || req_d) begin
            state     <= HALT_REQ;
            HaltCause <= {req_d, req_i};
            stall_q   <= 1'b1;
            Running   <= 1'b0;
          end
        end
        HALT_REQ: begin
          if (Halted) begin
            state   <= HALTED;
            stall_q <= 1'b0;
            HaltAck <= 1'b1;
          end else if (cnt_terminal) begin
            HaltTimeout <= 1'b1;
          end
        end
        HALTED: begin
          if (DebugResumeReq) begin
            state       <= RESTART;
            HaltAck     <= 1'b0;
            CoreSyncRst <= 1'b1;
          end
        end
        RESTART: begin
          if (cnt_zero) begin
            state       <= RUN;
            HaltCause   <= CAUSE_NONE;
            CoreSyncRst <= 1'b0;
            Running     <= 1'b1;
          end
        end
        default: begin
          state <= RESTART;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_controller.sv
// Randomized and directed bench for halt_controller against a phase/countdown reference model.
module tb_halt_controller;

  localparam int RC = 4;
  localparam int HT = 16;

  localparam int P_RUN     = 0;
  localparam int P_WAIT    = 1;
  localparam int P_HALTED  = 2;
  localparam int P_RESTART = 3;

  logic       clk = 1'b0;
  logic       async_rst;
  logic       clk_en;
  logic       InstructionValid;
  logic       HaltInstr;
  logic       DebugHaltReq;
  logic       DebugResumeReq;
  logic       Halted;
  logic       HaltStallOut;
  logic       CoreSyncRst;
  logic       HaltAck;
  logic [1:0] HaltCause;
  logic       HaltTimeout;
  logic       Running;

  always #5 clk = ~clk;

  halt_controller #(
    .RESTART_CYCLES (RC),
    .HALT_TIMEOUT   (HT)
  ) dut (
    .clk              (clk),
    .async_rst        (async_rst),
    .clk_en           (clk_en),
    .InstructionValid (InstructionValid),
    .HaltInstr        (HaltInstr),
    .DebugHaltReq     (DebugHaltReq),
    .DebugResumeReq   (DebugResumeReq),
    .Halted           (Halted),
    .HaltStallOut     (HaltStallOut),
    .CoreSyncRst      (CoreSyncRst),
    .HaltAck          (HaltAck),
    .HaltCause        (HaltCause),
    .HaltTimeout      (HaltTimeout),
    .Running          (Running)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: which phase the core is in, reset cycles left, clk_en cycles waited.
  int         phase;
  int         rst_left;
  int         en_waited;
  logic [1:0] m_cause;
  logic       m_tmo;

  function automatic bit instr_req();
    return InstructionValid && HaltInstr && clk_en;
  endfunction

  task automatic model_reset();
    phase     = P_RESTART;
    rst_left  = RC;
    en_waited = 0;
    m_cause   = 2'b00;
    m_tmo     = 1'b0;
  endtask

  task automatic model_step();
    bit ri;
    ri = instr_req();
    case (phase)
      P_RUN: if (ri || DebugHaltReq) begin
        phase     = P_WAIT;
        m_cause   = {DebugHaltReq, ri};
        en_waited = 0;
      end
      P_WAIT: if (Halted) phase = P_HALTED;
      else begin
        if (en_waited >= HT - 1) m_tmo = 1'b1;
        if (clk_en) en_waited++;
      end
      P_HALTED: if (DebugResumeReq) begin
        phase    = P_RESTART;
        rst_left = RC;
      end
      default: begin
        rst_left--;
        if (rst_left == 0) begin
          phase   = P_RUN;
          m_cause = 2'b00;
        end
      end
    endcase
  endtask

  task automatic compare();
    bit exp_stall;
    exp_stall = (phase == P_WAIT) || ((phase == P_RUN) && (instr_req() || DebugHaltReq));
    check("stall", HaltStallOut, exp_stall);
    check("csr", CoreSyncRst, phase == P_RESTART);
    check("ack", HaltAck, phase == P_HALTED);
    check("cause", HaltCause, m_cause);
    check("timeout", HaltTimeout, m_tmo);
    check("running", Running, phase == P_RUN);
  endtask

  // Inputs are set at the falling edge; outputs compared 1ns later; model advances on the rising edge.
  task automatic tick();
    if (async_rst) model_reset();
    #1;
    compare();
    @(posedge clk);
    if (async_rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic measure_pulse(output int len);
    len = 0;
    for (int i = 0; i < 50 && CoreSyncRst === 1'b1; i++) begin
      len++;
      tick();
    end
  endtask

  int pulse;
  int prev_phase;
  int ack_delay;
  int wait_cnt;

  initial begin
    async_rst        = 1'b1;
    clk_en           = 1'b0;
    InstructionValid = 1'b0;
    HaltInstr        = 1'b0;
    DebugHaltReq     = 1'b0;
    DebugResumeReq   = 1'b0;
    Halted           = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    tick();

    // Power-up pulse
    async_rst = 1'b0;
    measure_pulse(pulse);
    check("powerup_pulse_len", pulse, RC);
    check("powerup_running", Running, 1);

    // Instruction halt, Halted two cycles later
    clk_en = 1'b1; InstructionValid = 1'b1; HaltInstr = 1'b1;
    #1 check("instr_stall_same_cycle", HaltStallOut, 1);
    tick();
    InstructionValid = 1'b0; HaltInstr = 1'b0;
    tick();
    Halted = 1'b1;
    tick();
    check("instr_ack_latency", HaltAck, 1);
    check("instr_cause", HaltCause, 2'b01);

    // Resume from HALTED
    DebugResumeReq = 1'b1;
    tick();
    DebugResumeReq = 1'b0; Halted = 1'b0;
    measure_pulse(pulse);
    check("resume_pulse_len", pulse, RC);

    // Debug and instruction together; resume while waiting is ignored
    InstructionValid = 1'b1; HaltInstr = 1'b1; DebugHaltReq = 1'b1;
    tick();
    InstructionValid = 1'b0; HaltInstr = 1'b0; DebugHaltReq = 1'b0;
    DebugResumeReq = 1'b1;
    tick();
    DebugResumeReq = 1'b0;
    tick();
    check("both_cause", HaltCause, 2'b11);
    check("resume_ignored", CoreSyncRst, 0);
    Halted = 1'b1;
    tick();
    DebugResumeReq = 1'b1;
    tick();
    DebugResumeReq = 1'b0; Halted = 1'b0;
    measure_pulse(pulse);

    // Timeout with clk_en toggling, cleared only by reset
    DebugHaltReq = 1'b1;
    tick();
    DebugHaltReq = 1'b0;
    for (int i = 0; i < 40; i++) begin
      clk_en = i[0];
      tick();
    end
    check("timeout_set", HaltTimeout, 1);
    check("timeout_still_waiting", HaltStallOut, 1);
    async_rst = 1'b1;
    tick();
    check("timeout_cleared", HaltTimeout, 0);
    async_rst = 1'b0;
    clk_en = 1'b1;
    measure_pulse(pulse);

    // Resume with debug level held: re-halt from first RUN cycle
    DebugHaltReq = 1'b1;
    tick();
    Halted = 1'b1;
    tick();
    DebugResumeReq = 1'b1;
    tick();
    DebugResumeReq = 1'b0; Halted = 1'b0;
    measure_pulse(pulse);
    check("rehalt_pulse_len", pulse, RC);
    check("rehalt_run_stall", HaltStallOut, 1);
    check("rehalt_running", Running, 1);
    tick();
    check("rehalt_cause", HaltCause, 2'b10);
    check("rehalt_left_run", Running, 0);

    // Reset in the middle of the restart pulse
    DebugHaltReq = 1'b0; Halted = 1'b1;
    tick();
    DebugResumeReq = 1'b1;
    tick();
    DebugResumeReq = 1'b0; Halted = 1'b0;
    tick();
    tick();
    async_rst = 1'b1;
    tick();
    async_rst = 1'b0;
    measure_pulse(pulse);
    check("midreset_pulse_len", pulse, RC);

    // Random traffic
    ack_delay = 0;
    wait_cnt  = 0;
    for (int n = 0; n < 3000; n++) begin
      async_rst        = ($urandom_range(0, 299) == 0);
      clk_en           = $urandom_range(0, 1);
      InstructionValid = $urandom_range(0, 1);
      HaltInstr        = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) DebugHaltReq = ~DebugHaltReq;
      DebugResumeReq = (phase == P_HALTED) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 19) == 0);
      case (phase)
        P_WAIT: begin
          if (wait_cnt >= ack_delay) Halted = 1'b1;
          wait_cnt++;
        end
        P_HALTED: if ($urandom_range(0, 9) == 0) Halted = 1'b0;
        default: Halted = 1'b0;
      endcase
      prev_phase = phase;
      tick();
      if (phase == P_WAIT && prev_phase != P_WAIT) begin
        ack_delay = $urandom_range(0, 40);
        wait_cnt  = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
